// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
//   Forwarding and stall control for the 5-stage core, placed beside ID.
//   Picks, for every ID read port, whether the operand comes from the
//   register file or is forwarded from EX, MEM or WB. It also produces the
//   per-stage stall vector, the IF/ID flush and a saturating count of
//   stalled cycles.
//
//   Stall sources:
//     load-use : a load in EX feeds a register that ID reads -> 6'b000111
//     mul/div  : a multi-cycle op occupies EX for DIV_CYCLES -> 6'b001111
//   The mul/div stall wins over the load-use stall.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   rd_en/rd_addr   ID read ports; port i address in [i*AW +: AW]
//   ex_*/mem_*/wb_* destination info of the instructions in EX/MEM/WB
//   ex_mdiv_start   EX holds a newly issued mul/div
//   id_branch_tkn   ID resolved a taken branch
//   fwd_sel         port i select in [2i +: 2]: 00 rf, 01 EX, 10 MEM, 11 WB
//   stall           bit0 PC .. bit5 WB, 1 = hold that stage
//   flush_if        squash IF/ID
//   mdiv_busy       mul/div FSM is in its MDIV state
//   mdiv_done       pulse in the last mul/div stall cycle
//   stall_cycles    saturating count of cycles with stall != 0
module pipe_hazard_unit #(
   parameter int NREAD      = 2,
   parameter int AW         = 5,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREAD-1:0]     rd_en,
   input  logic [NREAD*AW-1:0]  rd_addr,
   input  logic                 ex_we,
   input  logic [AW-1:0]        ex_waddr,
   input  logic                 ex_mem2reg,
   input  logic                 mem_we,
   input  logic [AW-1:0]        mem_waddr,
   input  logic                 wb_we,
   input  logic [AW-1:0]        wb_waddr,
   input  logic                 ex_mdiv_start,
   input  logic                 id_branch_tkn,
   output logic [2*NREAD-1:0]   fwd_sel,
   output logic [5:0]           stall,
   output logic                 flush_if,
   output logic                 mdiv_busy,
   output logic                 mdiv_done,
   output logic [CNT_W-1:0]     stall_cycles
);

   localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

   typedef enum logic {IDLE, MDIV} state_t;

   state_t            state_reg;
   logic [CW-1:0]     cnt_reg;
   logic [CNT_W-1:0]  stall_cycles_reg;
   logic [NREAD-1:0]  lu_hit;
   logic              load_use;
   logic              mdiv_stall;

   // Per-port forwarding and load-use detection. Register 0 is hard-wired
   // zero, so it never matches a producer.
   generate
      for (genvar gi = 0; gi < NREAD; gi++) begin : g_port
         logic [AW-1:0] addr;
         logic          live;
         logic          ex_hit;
         logic          mem_hit;
         logic          wb_hit;

         assign addr    = rd_addr[gi*AW +: AW];
         assign live    = rd_en[gi] & (addr != '0);
         assign ex_hit  = live & ex_we  & (addr == ex_waddr);
         assign mem_hit = live & mem_we & (addr == mem_waddr);
         assign wb_hit  = live & wb_we  & (addr == wb_waddr);
         // Load-use does not depend on ex_we: a load in EX is enough.
         assign lu_hit[gi] = live & ex_mem2reg & (addr == ex_waddr);

         assign fwd_sel[2*gi +: 2] = rst     ? 2'b00 :
                                     ex_hit  ? 2'b01 :
                                     mem_hit ? 2'b10 :
                                     wb_hit  ? 2'b11 : 2'b00;
      end
   endgenerate

   assign load_use = |lu_hit;

   // The start cycle itself already stalls; in MDIV a new start is ignored
   // because EX is held anyway.
   assign mdiv_stall = (state_reg == MDIV) | ex_mdiv_start;

   always_comb begin
      stall = 6'b000000;
      if (!rst) begin
         if (mdiv_stall)
            stall = 6'b001111;
         else if (load_use)
            stall = 6'b000111;
      end
   end

   // A branch resolved in a held ID is retried once ID is released.
   assign flush_if  = ~rst & id_branch_tkn & ~stall[2];
   assign mdiv_busy = ~rst & (state_reg == MDIV);
   assign mdiv_done = mdiv_busy & (cnt_reg == CW'(1));

   assign stall_cycles = stall_cycles_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         cnt_reg          <= '0;
         stall_cycles_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (ex_mdiv_start) begin
                  state_reg <= MDIV;
                  cnt_reg   <= CW'(DIV_CYCLES - 1);
               end
            end
            MDIV: begin
               cnt_reg <= cnt_reg - CW'(1);
               if (cnt_reg == CW'(1))
                  state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
            end
         endcase

         if ((stall != 6'b000000) && (stall_cycles_reg != {CNT_W{1'b1}}))
            stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
      end
   end

endmodule
